// File: rtl/grt_pkg.sv
// Shared types and encodings for the GRT update responder: FSM states,
// command type encoding and the command-queue entry width.
package grt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } grt_state_e;

  localparam logic CMD_ALLOC   = 1'b0;
  localparam logic CMD_DEALLOC = 1'b1;

  // Queue entry layout, MSB first: {type, cu_id, wf_cnt, vgpr_cnt}
  function automatic int grt_entry_w(input int cu_w, input int wf_w, input int vgpr_w);
    return 1 + cu_w + wf_w + vgpr_w;
  endfunction

endpackage

// File: rtl/grt_cmd_fifo.sv
// Command queue with a two-wide write port (slot 0 lands first) and a single
// pop port. DEPTH must be a power of two so the pointers wrap naturally.
module grt_cmd_fifo #(
  parameter int ENTRY_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_data0,
  input  logic [ENTRY_W-1:0] i_wr_data1,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_rd_data,
  output logic               o_full,
  output logic               o_two_free,
  output logic               o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   w_wptr1;
  logic [PTR_W:0]     w_n_wr;
  logic               w_pop_ok;

  assign w_pop_ok   = i_pop & ~o_empty;
  assign w_wptr1    = r_wptr + PTR_W'(i_wr_en[0]);
  assign w_n_wr     = (PTR_W+1)'(i_wr_en[0]) + (PTR_W+1)'(i_wr_en[1]);
  assign o_rd_data  = r_mem[r_rptr];
  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_two_free = (r_count <= (PTR_W+1)'(DEPTH-2));
  assign o_empty    = (r_count == '0);

  always_ff @(posedge clk) begin
    if (i_wr_en[0]) r_mem[r_wptr]  <= i_wr_data0;
    if (i_wr_en[1]) r_mem[w_wptr1] <= i_wr_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + w_n_wr[PTR_W-1:0];
      r_rptr  <= r_rptr + PTR_W'(w_pop_ok);
      r_count <= r_count + w_n_wr - (PTR_W+1)'(w_pop_ok);
    end
  end

endmodule

// File: rtl/grt_update_responder.sv
// Responder for dispatch alloc/dealloc commands: queues them, applies each to
// the per-CU usage table in IDLE->READ->WRITE order and pulses done per command.
module grt_update_responder
  import grt_pkg::*;
#(
  parameter int NUMBER_CU       = 2,
  parameter int CU_ID_WIDTH     = 2,
  parameter int WF_CNT_WIDTH    = 4,
  parameter int VGPR_CNT_WIDTH  = 10,
  parameter int MAX_WF_PER_CU   = 8,
  parameter int MAX_VGPR_PER_CU = 512,
  parameter int CMD_FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wg_alloc_valid_i,
  input  logic                                wg_dealloc_valid_i,
  input  logic [CU_ID_WIDTH-1:0]              cmd_cu_id_i,
  input  logic [WF_CNT_WIDTH-1:0]             cmd_wf_cnt_i,
  input  logic [VGPR_CNT_WIDTH-1:0]           cmd_vgpr_cnt_i,
  output logic                                grt_wg_alloc_done_o,
  output logic [CU_ID_WIDTH-1:0]              grt_wg_alloc_cu_id_o,
  output logic                                grt_wg_dealloc_done_o,
  output logic [CU_ID_WIDTH-1:0]              grt_wg_dealloc_cu_id_o,
  output logic [NUMBER_CU*WF_CNT_WIDTH-1:0]   cu_wf_used_o,
  output logic [NUMBER_CU*VGPR_CNT_WIDTH-1:0] cu_vgpr_used_o,
  output logic                                cmd_fifo_full_o,
  output logic                                err_o
);

  localparam int ENTRY_W = grt_entry_w(CU_ID_WIDTH, WF_CNT_WIDTH, VGPR_CNT_WIDTH);
  localparam int WF_LSB  = VGPR_CNT_WIDTH;
  localparam int CU_LSB  = VGPR_CNT_WIDTH + WF_CNT_WIDTH;

  function automatic logic [WF_CNT_WIDTH:0] sat_wf(input logic is_dealloc,
      input logic [WF_CNT_WIDTH-1:0] old_v, input logic [WF_CNT_WIDTH-1:0] cnt);
    logic [WF_CNT_WIDTH:0] res;
    if (is_dealloc) begin
      res = {1'b0, old_v} - {1'b0, cnt};
      if (res[WF_CNT_WIDTH]) return {1'b1, {WF_CNT_WIDTH{1'b0}}};
      return {1'b0, res[WF_CNT_WIDTH-1:0]};
    end
    res = {1'b0, old_v} + {1'b0, cnt};
    if (res > (WF_CNT_WIDTH+1)'(MAX_WF_PER_CU)) return {1'b1, WF_CNT_WIDTH'(MAX_WF_PER_CU)};
    return {1'b0, res[WF_CNT_WIDTH-1:0]};
  endfunction

  function automatic logic [VGPR_CNT_WIDTH:0] sat_vgpr(input logic is_dealloc,
      input logic [VGPR_CNT_WIDTH-1:0] old_v, input logic [VGPR_CNT_WIDTH-1:0] cnt);
    logic [VGPR_CNT_WIDTH:0] res;
    if (is_dealloc) begin
      res = {1'b0, old_v} - {1'b0, cnt};
      if (res[VGPR_CNT_WIDTH]) return {1'b1, {VGPR_CNT_WIDTH{1'b0}}};
      return {1'b0, res[VGPR_CNT_WIDTH-1:0]};
    end
    res = {1'b0, old_v} + {1'b0, cnt};
    if (res > (VGPR_CNT_WIDTH+1)'(MAX_VGPR_PER_CU)) return {1'b1, VGPR_CNT_WIDTH'(MAX_VGPR_PER_CU)};
    return {1'b0, res[VGPR_CNT_WIDTH-1:0]};
  endfunction

  grt_state_e                r_state, w_state_nxt;
  logic [1:0]                w_wr_en;
  logic [ENTRY_W-1:0]        w_wr_d0, w_wr_d1, w_head;
  logic [ENTRY_W-2:0]        w_payload;
  logic                      w_drop, w_full, w_two_free, w_empty, w_pop, w_commit, w_cu_ok;
  logic                      r_cmd_type;
  logic [CU_ID_WIDTH-1:0]    r_cmd_cu;
  logic [WF_CNT_WIDTH-1:0]   r_cmd_wf, r_old_wf, w_sel_wf;
  logic [VGPR_CNT_WIDTH-1:0] r_cmd_vgpr, r_old_vgpr, w_sel_vgpr;
  logic [WF_CNT_WIDTH:0]     w_wf_res;
  logic [VGPR_CNT_WIDTH:0]   w_vgpr_res;
  logic [WF_CNT_WIDTH-1:0]   r_wf_used   [NUMBER_CU];
  logic [VGPR_CNT_WIDTH-1:0] r_vgpr_used [NUMBER_CU];
  logic                      r_alloc_done, r_dealloc_done, r_err;
  logic [CU_ID_WIDTH-1:0]    r_alloc_cu, r_dealloc_cu;

  assign w_payload = {cmd_cu_id_i, cmd_wf_cnt_i, cmd_vgpr_cnt_i};

  // Same-cycle pair goes in as dealloc then alloc, and only as a pair
  always_comb begin
    w_wr_en = 2'b00;
    w_drop  = 1'b0;
    w_wr_d0 = {CMD_ALLOC, w_payload};
    w_wr_d1 = {CMD_ALLOC, w_payload};
    if (wg_alloc_valid_i && wg_dealloc_valid_i) begin
      w_wr_d0 = {CMD_DEALLOC, w_payload};
      if (w_two_free) w_wr_en = 2'b11;
      else            w_drop  = 1'b1;
    end else if (wg_alloc_valid_i || wg_dealloc_valid_i) begin
      w_wr_d0 = {(wg_dealloc_valid_i ? CMD_DEALLOC : CMD_ALLOC), w_payload};
      if (!w_full) w_wr_en = 2'b01;
      else         w_drop  = 1'b1;
    end
  end

  grt_cmd_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (w_wr_en),
    .i_wr_data0 (w_wr_d0),
    .i_wr_data1 (w_wr_d1),
    .i_pop      (w_pop),
    .o_rd_data  (w_head),
    .o_full     (w_full),
    .o_two_free (w_two_free),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = ST_READ;
      end
      ST_READ:  w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_wf   = '0;
    w_sel_vgpr = '0;
    for (int i = 0; i < NUMBER_CU; i++) begin
      if (r_cmd_cu == CU_ID_WIDTH'(i)) begin
        w_sel_wf   = r_wf_used[i];
        w_sel_vgpr = r_vgpr_used[i];
      end
    end
  end

  assign w_cu_ok    = ({1'b0, r_cmd_cu} < (CU_ID_WIDTH+1)'(NUMBER_CU));
  assign w_wf_res   = sat_wf(r_cmd_type, r_old_wf, r_cmd_wf);
  assign w_vgpr_res = sat_vgpr(r_cmd_type, r_old_vgpr, r_cmd_vgpr);

  // Pop -> command regs; READ -> working copy of the target CU's usage
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_cmd_type <= w_head[ENTRY_W-1];
      r_cmd_cu   <= w_head[CU_LSB +: CU_ID_WIDTH];
      r_cmd_wf   <= w_head[WF_LSB +: WF_CNT_WIDTH];
      r_cmd_vgpr <= w_head[VGPR_CNT_WIDTH-1:0];
    end
    if (r_state == ST_READ) begin
      r_old_wf   <= w_sel_wf;
      r_old_vgpr <= w_sel_vgpr;
    end
  end

  // WRITE -> table write-back and done pulse visible next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER_CU; i++) begin
        r_wf_used[i]   <= '0;
        r_vgpr_used[i] <= '0;
      end
      r_alloc_done   <= 1'b0;
      r_dealloc_done <= 1'b0;
      r_alloc_cu     <= '0;
      r_dealloc_cu   <= '0;
      r_err          <= 1'b0;
    end else begin
      r_alloc_done   <= 1'b0;
      r_dealloc_done <= 1'b0;
      if (w_commit) begin
        if (r_cmd_type == CMD_DEALLOC) begin
          r_dealloc_done <= 1'b1;
          r_dealloc_cu   <= r_cmd_cu;
        end else begin
          r_alloc_done <= 1'b1;
          r_alloc_cu   <= r_cmd_cu;
        end
        for (int i = 0; i < NUMBER_CU; i++) begin
          if (w_cu_ok && (r_cmd_cu == CU_ID_WIDTH'(i))) begin
            r_wf_used[i]   <= w_wf_res[WF_CNT_WIDTH-1:0];
            r_vgpr_used[i] <= w_vgpr_res[VGPR_CNT_WIDTH-1:0];
          end
        end
      end
      if (w_drop || (w_commit && (!w_cu_ok || w_wf_res[WF_CNT_WIDTH] || w_vgpr_res[VGPR_CNT_WIDTH])))
        r_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUMBER_CU; g++) begin : g_flat
    assign cu_wf_used_o[g*WF_CNT_WIDTH +: WF_CNT_WIDTH]       = r_wf_used[g];
    assign cu_vgpr_used_o[g*VGPR_CNT_WIDTH +: VGPR_CNT_WIDTH] = r_vgpr_used[g];
  end

  assign grt_wg_alloc_done_o    = r_alloc_done;
  assign grt_wg_alloc_cu_id_o   = r_alloc_cu;
  assign grt_wg_dealloc_done_o  = r_dealloc_done;
  assign grt_wg_dealloc_cu_id_o = r_dealloc_cu;
  assign cmd_fifo_full_o        = w_full;
  assign err_o                  = r_err;

endmodule

// File: tb/tb_grt_update_responder.sv
// Directed bench for grt_update_responder: a table of single commands, then
// hand-written pair, overflow, mid-operation reset and random model sequences.
module tb_grt_update_responder;

  localparam int NCU = 2, CU_W = 2, WF_W = 4, VG_W = 10, MAX_WF = 8, MAX_VG = 512, DEPTH = 4;

  logic clk, rst_n;
  logic alloc_v, dealloc_v;
  logic [CU_W-1:0] cu_id;
  logic [WF_W-1:0] wf_cnt;
  logic [VG_W-1:0] vg_cnt;
  logic ad, dd, full, err;
  logic [CU_W-1:0] acu, dcu;
  logic [NCU*WF_W-1:0] wf_used;
  logic [NCU*VG_W-1:0] vg_used;

  grt_update_responder #(
    .NUMBER_CU(NCU), .CU_ID_WIDTH(CU_W), .WF_CNT_WIDTH(WF_W), .VGPR_CNT_WIDTH(VG_W),
    .MAX_WF_PER_CU(MAX_WF), .MAX_VGPR_PER_CU(MAX_VG), .CMD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wg_alloc_valid_i(alloc_v), .wg_dealloc_valid_i(dealloc_v),
    .cmd_cu_id_i(cu_id), .cmd_wf_cnt_i(wf_cnt), .cmd_vgpr_cnt_i(vg_cnt),
    .grt_wg_alloc_done_o(ad), .grt_wg_alloc_cu_id_o(acu),
    .grt_wg_dealloc_done_o(dd), .grt_wg_dealloc_cu_id_o(dcu),
    .cu_wf_used_o(wf_used), .cu_vgpr_used_o(vg_used),
    .cmd_fifo_full_o(full), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic d, input int cu, input int wf, input int vg);
    alloc_v   = a;
    dealloc_v = d;
    cu_id     = CU_W'(cu);
    wf_cnt    = WF_W'(wf);
    vg_cnt    = VG_W'(vg);
  endtask

  function automatic logic [31:0] get_wf(input int i);
    return 32'(wf_used[i*WF_W +: WF_W]);
  endfunction

  function automatic logic [31:0] get_vg(input int i);
    return 32'(vg_used[i*VG_W +: VG_W]);
  endfunction

  typedef struct {
    logic a, d;
    int   cu, wf, vg;
    logic exp_ad, exp_dd;
    int   wf0, wf1, vg0, vg1;
    logic err;
  } vec_t;

  function automatic vec_t mk(input int a, d, cu, wf, vg, ead, edd, wf0, wf1, vg0, vg1, e);
    vec_t v;
    v.a = 1'(a); v.d = 1'(d); v.cu = cu; v.wf = wf; v.vg = vg;
    v.exp_ad = 1'(ead); v.exp_dd = 1'(edd);
    v.wf0 = wf0; v.wf1 = wf1; v.vg0 = vg0; v.vg1 = vg1; v.err = 1'(e);
    return v;
  endfunction

  typedef struct { logic t; int cu; int wf; int vg; } cmd_t;
  cmd_t q[$];
  int m_wf[NCU], m_vg[NCU];
  logic m_err;

  task automatic model_apply(input cmd_t c);
    int nw, nv;
    if (c.t) begin
      nw = m_wf[c.cu] - c.wf;
      nv = m_vg[c.cu] - c.vg;
      if (nw < 0) begin nw = 0; m_err = 1'b1; end
      if (nv < 0) begin nv = 0; m_err = 1'b1; end
    end else begin
      nw = m_wf[c.cu] + c.wf;
      nv = m_vg[c.cu] + c.vg;
      if (nw > MAX_WF) begin nw = MAX_WF; m_err = 1'b1; end
      if (nv > MAX_VG) begin nv = MAX_VG; m_err = 1'b1; end
    end
    m_wf[c.cu] = nw;
    m_vg[c.cu] = nv;
  endtask

  vec_t vecs[11];

  initial begin
    logic early;
    int n_ad, n_dd, n_ov, idx;
    logic exp_t[6];
    int exp_cu[6], exp_cyc[6];
    cmd_t c;

    vecs[0]  = mk(1,0,1,3,64,    1,0, 0,3,0,64,    0);
    vecs[1]  = mk(1,0,0,2,100,   1,0, 2,3,100,64,  0);
    vecs[2]  = mk(0,1,1,1,32,    0,1, 2,2,100,32,  0);
    vecs[3]  = mk(1,0,0,6,412,   1,0, 8,2,512,32,  0);
    vecs[4]  = mk(0,1,0,8,512,   0,1, 0,2,0,32,    0);
    vecs[5]  = mk(1,0,0,6,0,     1,0, 6,2,0,32,    0);
    vecs[6]  = mk(1,0,0,6,0,     1,0, 8,2,0,32,    1);
    vecs[7]  = mk(0,1,1,3,40,    0,1, 8,0,0,0,     1);
    vecs[8]  = mk(1,0,2,1,1,     1,0, 8,0,0,0,     1);
    vecs[9]  = mk(0,1,3,1,1,     0,1, 8,0,0,0,     1);
    vecs[10] = mk(1,0,1,1,1000,  1,0, 8,1,0,512,   1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_alloc_done", 32'(ad), 0);
    check("rst_dealloc_done", 32'(dd), 0);
    check("rst_alloc_cu", 32'(acu), 0);
    check("rst_dealloc_cu", 32'(dcu), 0);
    check("rst_wf_used", 32'(wf_used), 0);
    check("rst_vgpr_used", 32'(vg_used), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // Table: each command issued from an idle responder
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].a, vecs[v].d, vecs[v].cu, vecs[v].wf, vecs[v].vg);
      early = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (k == 0) drive(0, 0, 0, 0, 0);
        early |= ad | dd;
      end
      check($sformatf("vec%0d_early_done", v), 32'(early), 0);
      tick();
      check($sformatf("vec%0d_alloc_done", v), 32'(ad), 32'(vecs[v].exp_ad));
      check($sformatf("vec%0d_dealloc_done", v), 32'(dd), 32'(vecs[v].exp_dd));
      check($sformatf("vec%0d_cu_id", v), vecs[v].exp_ad ? 32'(acu) : 32'(dcu), 32'(vecs[v].cu));
      check($sformatf("vec%0d_wf0", v), get_wf(0), 32'(vecs[v].wf0));
      check($sformatf("vec%0d_wf1", v), get_wf(1), 32'(vecs[v].wf1));
      check($sformatf("vec%0d_vg0", v), get_vg(0), 32'(vecs[v].vg0));
      check($sformatf("vec%0d_vg1", v), get_vg(1), 32'(vecs[v].vg1));
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].err));
      tick();
      check($sformatf("vec%0d_pulse_width", v), 32'(ad | dd), 0);
      check($sformatf("vec%0d_cu_hold", v), vecs[v].exp_ad ? 32'(acu) : 32'(dcu), 32'(vecs[v].cu));
    end

    // Same-cycle dealloc+alloc on cu0 starting from wf=2
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    check("s2_rst_err", 32'(err), 0);
    drive(1, 0, 0, 2, 0);
    tick(); drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    check("s2_pre_wf0", get_wf(0), 2);
    drive(1, 1, 0, 1, 0);
    n_ad = 0; n_dd = 0; n_ov = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc == 1) drive(0, 0, 0, 0, 0);
      if (ad && dd) n_ov++;
      if (dd) begin
        n_dd++;
        check("s2_dealloc_cycle", 32'(cyc), 4);
        check("s2_wf0_after_dealloc", get_wf(0), 1);
      end
      if (ad) begin
        n_ad++;
        check("s2_alloc_cycle", 32'(cyc), 7);
        check("s2_wf0_after_alloc", get_wf(0), 2);
      end
    end
    check("s2_dealloc_pulses", 32'(n_dd), 1);
    check("s2_alloc_pulses", 32'(n_ad), 1);
    check("s2_overlap", 32'(n_ov), 0);
    check("s2_err", 32'(err), 0);

    // Queue overflow: two deallocs keep the FSM busy, then five allocs
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    drive(1, 0, 1, 4, 0);
    tick(); drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) tick();
    check("s3_pre_err", 32'(err), 0);
    exp_t   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_cu  = '{1, 1, 0, 1, 0, 1};
    exp_cyc = '{4, 7, 10, 13, 16, 19};
    idx = 0; n_ov = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (cyc < 2)      drive(0, 1, 1, 1, 0);
      else if (cyc < 7) drive(1, 0, (cyc - 2) % 2, 1, 1);
      else              drive(0, 0, 0, 0, 0);
      tick();
      if (cyc == 4) check("s3_not_full_c5", 32'(full), 0);
      if (cyc == 5) check("s3_full_c6", 32'(full), 1);
      if (ad && dd) n_ov++;
      if (ad || dd) begin
        if (idx < 6) begin
          check($sformatf("s3_ev%0d_type", idx), 32'(dd), 32'(exp_t[idx]));
          check($sformatf("s3_ev%0d_cu", idx), dd ? 32'(dcu) : 32'(acu), 32'(exp_cu[idx]));
          check($sformatf("s3_ev%0d_cycle", idx), 32'(cyc + 1), 32'(exp_cyc[idx]));
        end
        idx++;
      end
    end
    check("s3_done_count", 32'(idx), 6);
    check("s3_overlap", 32'(n_ov), 0);
    check("s3_err_drop", 32'(err), 1);
    check("s3_wf0", get_wf(0), 2);
    check("s3_wf1", get_wf(1), 4);
    check("s3_vg0", get_vg(0), 2);
    check("s3_vg1", get_vg(1), 2);

    // Reset asserted while a command sits in READ
    drive(1, 0, 0, 5, 5);
    tick(); drive(0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("s5_async_wf", 32'(wf_used), 0);
    check("s5_async_vg", 32'(vg_used), 0);
    check("s5_async_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;
    n_ad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ad || dd) n_ad++;
    end
    check("s5_no_stale_done", 32'(n_ad), 0);
    check("s5_wf_zero", 32'(wf_used), 0);
    check("s5_full", 32'(full), 0);
    drive(1, 0, 1, 2, 8);
    early = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) drive(0, 0, 0, 0, 0);
      early |= ad | dd;
    end
    check("s5_new_early", 32'(early), 0);
    tick();
    check("s5_new_alloc_done", 32'(ad), 1);
    check("s5_new_cu", 32'(acu), 1);
    check("s5_new_wf1", get_wf(1), 2);
    check("s5_new_vg1", get_vg(1), 8);

    // Random stream against the reference model
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < NCU; i++) begin m_wf[i] = 0; m_vg[i] = 0; end
    m_err = 1'b0;
    q.delete();
    n_ov = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(0, 0, 0, 0, 0);
      if (cyc < 340 && q.size() <= 2 && $urandom_range(0, 2) == 0) begin
        int kind;
        kind = int'($urandom_range(0, 4));
        c.cu = int'($urandom_range(0, 1));
        c.wf = int'($urandom_range(0, 5));
        c.vg = int'($urandom_range(0, 300));
        if (kind == 4) begin
          drive(1, 1, c.cu, c.wf, c.vg);
          c.t = 1'b1; q.push_back(c);
          c.t = 1'b0; q.push_back(c);
        end else begin
          c.t = (kind >= 2);
          drive(!c.t, c.t, c.cu, c.wf, c.vg);
          q.push_back(c);
        end
      end
      tick();
      if (ad && dd) n_ov++;
      if (ad || dd) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_done", 1, 0);
        end else begin
          c = q.pop_front();
          model_apply(c);
          check("rnd_type", 32'(dd), 32'(c.t));
          check("rnd_cu", dd ? 32'(dcu) : 32'(acu), 32'(c.cu));
          check("rnd_wf0", get_wf(0), 32'(m_wf[0]));
          check("rnd_wf1", get_wf(1), 32'(m_wf[1]));
          check("rnd_vg0", get_vg(0), 32'(m_vg[0]));
          check("rnd_vg1", get_vg(1), 32'(m_vg[1]));
          check("rnd_err", 32'(err), 32'(m_err));
        end
      end
    end
    check("rnd_all_done", 32'(q.size()), 0);
    check("rnd_overlap", 32'(n_ov), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
